// File: rtl/exception_sequencer.sv
// Exception entry/return sequencer for the 5-stage MIPS pipeline.
// Optional EXC_COUNT_EN adds a saturating accepted-exception counter.
module exception_sequencer #(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0000_0180,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ov,
    input  logic        exc,
    input  logic        irq,
    input  logic [31:0] ex_pc,
    input  logic [31:0] id_pc,
    input  logic        eret,
    output logic        flush_if,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic [4:0]  cause,
    output logic        in_handler,
    output logic        double_fault,
`ifdef EXC_COUNT_EN
    output logic [15:0] exc_count,
`endif
    output logic        busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FLUSH   = 3'd1;
    localparam logic [2:0] S_ENTER   = 3'd2;
    localparam logic [2:0] S_HANDLER = 3'd3;
    localparam logic [2:0] S_RETURN  = 3'd4;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    logic [2:0] state;
    logic [3:0] cnt;
    logic       take;

    assign take = (state == S_IDLE) && (ov || exc || irq);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            flush_if     <= 1'b0;
            flush_id     <= 1'b0;
            flush_ex     <= 1'b0;
            pc_redirect  <= 1'b0;
            redirect_pc  <= 32'h0;
            epc          <= 32'h0;
            cause        <= 5'd0;
            in_handler   <= 1'b0;
            double_fault <= 1'b0;
            busy         <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (take) begin
                        state    <= S_FLUSH;
                        cnt      <= CNT_INIT;
                        flush_if <= 1'b1;
                        flush_id <= 1'b1;
                        flush_ex <= ov;
                        busy     <= 1'b1;
                        if (ov) begin
                            epc   <= ex_pc;
                            cause <= 5'd12;
                        end else if (exc) begin
                            epc   <= id_pc;
                            cause <= 5'd10;
                        end else begin
                            epc   <= id_pc;
                            cause <= 5'd0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (cnt == 4'd0) begin
                        state       <= S_ENTER;
                        flush_if    <= 1'b0;
                        flush_id    <= 1'b0;
                        flush_ex    <= 1'b0;
                        pc_redirect <= 1'b1;
                        redirect_pc <= VECTOR_ADDR;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ENTER: begin
                    state       <= S_HANDLER;
                    pc_redirect <= 1'b0;
                    in_handler  <= 1'b1;
                end
                S_HANDLER: begin
                    // eret wins over a simultaneous fault, which is dropped
                    if (eret) begin
                        state       <= S_RETURN;
                        pc_redirect <= 1'b1;
                        redirect_pc <= epc;
                        flush_if    <= 1'b1;
                    end else if (ov || exc) begin
                        double_fault <= 1'b1;
                    end
                end
                S_RETURN: begin
                    state       <= S_IDLE;
                    pc_redirect <= 1'b0;
                    flush_if    <= 1'b0;
                    in_handler  <= 1'b0;
                    busy        <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    flush_if    <= 1'b0;
                    flush_id    <= 1'b0;
                    flush_ex    <= 1'b0;
                    pc_redirect <= 1'b0;
                    in_handler  <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef EXC_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_count <= 16'd0;
        end else if (take && exc_count != 16'hFFFF) begin
            exc_count <= exc_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exception_sequencer.sv
// Scoreboard bench for exception_sequencer: expected redirect targets
// are queued when events are driven and popped when pc_redirect fires.
module tb_exception_sequencer;

    localparam int          FC  = 2;
    localparam logic [31:0] VEC = 32'h0000_0180;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ov = 1'b0;
    logic        exc = 1'b0;
    logic        irq = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic [31:0] id_pc = 32'h0;
    logic        flush_if, flush_id, flush_ex, pc_redirect;
    logic [31:0] redirect_pc, epc;
    logic [4:0]  cause;
    logic        in_handler, double_fault, busy;
`ifdef EXC_COUNT_EN
    logic [15:0] exc_count;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];

    exception_sequencer #(
        .VECTOR_ADDR (VEC),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ov          (ov),
        .exc         (exc),
        .irq         (irq),
        .ex_pc       (ex_pc),
        .id_pc       (id_pc),
        .eret        (eret),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .flush_ex    (flush_ex),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .epc         (epc),
        .cause       (cause),
        .in_handler  (in_handler),
        .double_fault(double_fault),
`ifdef EXC_COUNT_EN
        .exc_count   (exc_count),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Redirect monitor: every strobe must match the oldest queued target
    always @(negedge clk) begin
        if (!reset && pc_redirect) begin
            if (sb.size() == 0) begin
                check("unexpected_redirect", 32'd1, 32'd0);
            end else begin
                check("redirect_pc", redirect_pc, sb.pop_front());
            end
        end
    end

    task automatic enter(input logic o, input logic e, input logic i,
                         input logic [31:0] xpc, input logic [31:0] ipc,
                         input logic [31:0] exp_epc, input logic [4:0] exp_cause);
        ex_pc = xpc;
        id_pc = ipc;
        ov = o;
        exc = e;
        irq = i;
        sb.push_back(VEC);
        step();
        ov = 1'b0;
        exc = 1'b0;
        irq = 1'b0;
        for (int k = 0; k < FC; k++) begin
            check("flush_if", {31'd0, flush_if}, 32'd1);
            check("flush_id", {31'd0, flush_id}, 32'd1);
            check("flush_ex", {31'd0, flush_ex}, {31'd0, exp_cause == 5'd12});
            check("flush_redir", {31'd0, pc_redirect}, 32'd0);
            check("busy_flush", {31'd0, busy}, 32'd1);
            if (k == 0) begin
                check("epc", epc, exp_epc);
                check("cause", {27'd0, cause}, {27'd0, exp_cause});
            end
            step();
        end
        check("enter_redir", {31'd0, pc_redirect}, 32'd1);
        check("enter_flush", {29'd0, flush_if, flush_id, flush_ex}, 32'd0);
        check("enter_inh", {31'd0, in_handler}, 32'd0);
        step();
        check("handler_inh", {31'd0, in_handler}, 32'd1);
        check("handler_redir", {31'd0, pc_redirect}, 32'd0);
        check("handler_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic ret(input logic [31:0] exp_epc, input logic with_exc);
        eret = 1'b1;
        exc = with_exc;
        sb.push_back(exp_epc);
        step();
        eret = 1'b0;
        exc = 1'b0;
        check("ret_redir", {31'd0, pc_redirect}, 32'd1);
        check("ret_flush_if", {31'd0, flush_if}, 32'd1);
        check("ret_flush_ex", {31'd0, flush_ex}, 32'd0);
        step();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_inh", {31'd0, in_handler}, 32'd0);
        check("idle_redir", {31'd0, pc_redirect}, 32'd0);
        check("idle_flush_if", {31'd0, flush_if}, 32'd0);
    endtask

    initial begin
        #12;
        check("rst_flush", {29'd0, flush_if, flush_id, flush_ex}, 32'd0);
        check("rst_redir", {31'd0, pc_redirect}, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_epc", epc, 32'd0);
        check("rst_state", {28'd0, busy, in_handler, double_fault, |cause}, 32'd0);
        reset = 1'b0;
        step();

        // eret in IDLE is ignored
        eret = 1'b1;
        step();
        eret = 1'b0;
        check("eret_idle_busy", {31'd0, busy}, 32'd0);
        step();

        enter(1'b1, 1'b0, 1'b0, 32'h24, 32'h28, 32'h24, 5'd12);
        ret(32'h24, 1'b0);

        enter(1'b1, 1'b1, 1'b1, 32'h40, 32'h44, 32'h40, 5'd12);
        ret(32'h40, 1'b0);

        enter(1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h100, 5'd10);
        ret(32'h100, 1'b0);
        check("hold_epc", epc, 32'h100);
        check("hold_cause", {27'd0, cause}, 32'd10);

        // irq masked in handler, then a double fault, then eret+exc
        enter(1'b0, 1'b0, 1'b1, 32'h0, 32'h200, 32'h200, 5'd0);
        irq = 1'b1;
        step();
        step();
        irq = 1'b0;
        check("mask_redir", {31'd0, pc_redirect}, 32'd0);
        check("mask_inh", {31'd0, in_handler}, 32'd1);
        check("mask_df", {31'd0, double_fault}, 32'd0);
        ex_pc = 32'h999;
        ov = 1'b1;
        step();
        ov = 1'b0;
        check("df_set", {31'd0, double_fault}, 32'd1);
        check("df_epc", epc, 32'h200);
        check("df_cause", {27'd0, cause}, 32'd0);
        check("df_redir", {31'd0, pc_redirect}, 32'd0);
        check("df_inh", {31'd0, in_handler}, 32'd1);
        ret(32'h200, 1'b1);
        check("df_sticky", {31'd0, double_fault}, 32'd1);
        check("ret_epc_hold", epc, 32'h200);

        // asynchronous reset during the first flush cycle
        id_pc = 32'h300;
        exc = 1'b1;
        step();
        exc = 1'b0;
        check("pre_rst_flush", {31'd0, flush_if}, 32'd1);
        reset = 1'b1;
        #1;
        check("arst_flush", {29'd0, flush_if, flush_id, flush_ex}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_epc", epc, 32'd0);
        check("arst_df", {31'd0, double_fault}, 32'd0);
        sb.delete();
        #3;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("post_rst_redir", {31'd0, pc_redirect}, 32'd0);
        end
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        enter(1'b0, 1'b0, 1'b1, 32'h0, 32'h400, 32'h400, 5'd0);
        ret(32'h400, 1'b0);
`ifdef EXC_COUNT_EN
        check("exc_count", {16'd0, exc_count}, 32'd1);
`endif
        step();
        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
